ysyx_24090003_regfile_sb: RTL and testbench
===========================================

YSYX_24090003_REGFILE_SB -- requirements
Module: ysyx_24090003_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width.
REQ-002 SHALL have parameter AW, default 5: register address width; NREG = 2**AW (AW=4 gives the RV32E 16-register file).
REQ-003 SHALL have parameter BYPASS, default 1: 1 = a same-cycle writeback is forwarded to the read ports; 0 = no forwarding.
REQ-004 SHALL have port cpu_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port cpu_rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have ports rs1 and rs2, input, AW each: read addresses.
REQ-007 SHALL have ports rdata1 and rdata2, output, XLEN each: read data, combinational.
REQ-008 SHALL have ports rs1_busy and rs2_busy, output, 1 each: the source register has a write pending.
REQ-009 SHALL have port raw_stall, output, 1: rs1_busy OR rs2_busy, qualified by rs1_used and rs2_used.
REQ-010 SHALL have ports rs1_used and rs2_used, input, 1 each: the instruction actually reads that source.
REQ-011 SHALL have ports iss_valid (input, 1) and iss_rd (input, AW): issue of an instruction that will write iss_rd.
REQ-012 SHALL have ports wb_valid (input, 1), wb_rd (input, AW) and wb_data (input, XLEN): writeback.

Function
REQ-013 SHALL hardwire register 0: reads of address 0 return 0; writes and issues to address 0 are ignored; busy[0] is always 0.
REQ-014 SHALL, when wb_valid=1 and wb_rd!=0, write wb_data into reg[wb_rd] at the rising edge.
REQ-015 SHALL, with BYPASS=1, return wb_data on rdataN in the same cycle when wb_valid=1 and wb_rd==rsN!=0.
REQ-016 SHALL, with BYPASS=0, return the old register contents in that case; the new value is visible from the next cycle.
REQ-017 SHALL keep one busy bit per register: set at the edge when iss_valid=1 and iss_rd!=0; cleared at the edge when wb_valid=1 and wb_rd!=0.
REQ-018 SHALL, when issue and writeback target the same register in the same cycle, leave the busy bit SET (the new issue wins).
REQ-019 SHALL drive rsN_busy combinationally as busy[rsN].
REQ-020 SHALL, with BYPASS=1, clear rsN_busy in a cycle where a writeback to rsN is occurring, unless an issue to rsN occurs in the same cycle.
REQ-021 SHALL compute raw_stall = (rs1_used & rs1_busy) | (rs2_used & rs2_busy).
REQ-022 SHALL have no internal latency other than one edge for writes and busy updates; no multi-cycle state.
REQ-023 SHALL, on a writeback to a register that is not busy (iss was to a different register), perform the write and leave busy at 0; there is no error output.

Reset
REQ-024 SHALL, when cpu_rst_n=0 at a rising edge, clear all registers to 0 and all busy bits to 0; a writeback or issue in that cycle is discarded.
REQ-025 SHALL, in the cycle after reset, return rdata1=rdata2=0, rsN_busy=0 and raw_stall=0 for every address.
REQ-026 SHALL treat a reset asserted while writes are pending the same as any other reset: all pending busy bits are lost.

Structure
REQ-027 SHALL take the XLEN, AW and BYPASS defaults from the shared package ysyx_24090003_pkg, together with the REG_ZERO constant.
REQ-028 SHALL place the busy-bit logic in the sub-module ysyx_24090003_scoreboard (parameter AW); the data array and the bypass muxes stay in the top module.

Verification
REQ-029 SHALL cover reset then a sweep of reads of addresses 0..NREG-1 -> all rdata=0 and all busy=0.
REQ-030 SHALL cover wb x5=0xDEADBEEF with rs1=5 in the same cycle -> with BYPASS=1 rdata1=0xDEADBEEF in that cycle; with BYPASS=0 the old value (0) in that cycle and 0xDEADBEEF next cycle.
REQ-031 SHALL cover issue x7, then rs2=7 with rs2_used=1 -> raw_stall=1 until the wb to x7; with BYPASS=1 raw_stall=0 in the wb cycle.
REQ-032 SHALL cover issue x3 and wb x3 in the same cycle -> busy[3]=1 after the edge; the register holds the wb data.
REQ-033 SHALL cover wb x0=0x12345678 and issue x0 -> rdata=0 and busy=0 for address 0.
REQ-034 SHALL cover issue x9, then cpu_rst_n=0 for one cycle during a wb to x9 -> x9=0, busy[9]=0 and raw_stall=0.

Source files
------------

// File: rtl/ysyx_24090003_pkg.sv
// Shared defaults for the integer register file and its scoreboard.
package ysyx_24090003_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int AW_DEF     = 5;
  localparam int BYPASS_DEF = 1;
  localparam int REG_ZERO   = 0;

  function automatic int nreg(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ysyx_24090003_regfile_sb_if.sv
// Read, issue and writeback bundle between the pipeline (master) and the register file (slave).
interface ysyx_24090003_regfile_sb_if
  import ysyx_24090003_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_used;
  logic            rs2_used;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            raw_stall;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output rs1, rs2, rs1_used, rs2_used, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
    input  rdata1, rdata2, rs1_busy, rs2_busy, raw_stall
  );

  modport slave (
    input  rs1, rs2, rs1_used, rs2_used, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
    output rdata1, rdata2, rs1_busy, rs2_busy, raw_stall
  );

endinterface

// File: rtl/ysyx_24090003_scoreboard.sv
// One pending-write bit per register; an issue and a writeback to the same register leave it set.
module ysyx_24090003_scoreboard
  import ysyx_24090003_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst_n,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_rd,
  output logic [(2**AW)-1:0] busy
);

  localparam int NREG = nreg(AW);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREG-1:0] set_v;
  logic [NREG-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_valid && (iss_rd != ZERO_ADDR)) set_v[iss_rd] = 1'b1;
    if (wb_valid && (wb_rd != ZERO_ADDR)) clr_v[wb_rd] = 1'b1;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) busy <= '0;
    else            busy <= (busy & ~clr_v) | set_v;
  end

endmodule

// File: rtl/ysyx_24090003_regfile_sb.sv
// Integer register file with x0 hardwired, optional writeback forwarding and a RAW scoreboard.
module ysyx_24090003_regfile_sb
  import ysyx_24090003_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int BYPASS = BYPASS_DEF
) (
  input logic                        cpu_clk,
  input logic                        cpu_rst_n,
  ysyx_24090003_regfile_sb_if.slave  rf
);

  localparam int NREG = nreg(AW);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wb_en;
  logic            wb_hit1;
  logic            wb_hit2;
  logic            iss_hit1;
  logic            iss_hit2;

  ysyx_24090003_scoreboard #(.AW(AW)) u_sb (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .iss_valid (rf.iss_valid),
    .iss_rd    (rf.iss_rd),
    .wb_valid  (rf.wb_valid),
    .wb_rd     (rf.wb_rd),
    .busy      (busy)
  );

  assign wb_en = rf.wb_valid && (rf.wb_rd != ZERO_ADDR);

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[rf.wb_rd] <= rf.wb_data;
    end
  end

  assign wb_hit1  = wb_en && (rf.wb_rd == rf.rs1);
  assign wb_hit2  = wb_en && (rf.wb_rd == rf.rs2);
  assign iss_hit1 = rf.iss_valid && (rf.iss_rd == rf.rs1) && (rf.rs1 != ZERO_ADDR);
  assign iss_hit2 = rf.iss_valid && (rf.iss_rd == rf.rs2) && (rf.rs2 != ZERO_ADDR);

  always_comb begin
    rf.rdata1 = regs[rf.rs1];
    if (rf.rs1 == ZERO_ADDR)           rf.rdata1 = '0;
    else if ((BYPASS != 0) && wb_hit1) rf.rdata1 = rf.wb_data;
  end

  always_comb begin
    rf.rdata2 = regs[rf.rs2];
    if (rf.rs2 == ZERO_ADDR)           rf.rdata2 = '0;
    else if ((BYPASS != 0) && wb_hit2) rf.rdata2 = rf.wb_data;
  end

  // A forwarded writeback resolves the hazard now, unless a fresh issue re-claims the register.
  assign rf.rs1_busy  = busy[rf.rs1] && !((BYPASS != 0) && wb_hit1 && !iss_hit1);
  assign rf.rs2_busy  = busy[rf.rs2] && !((BYPASS != 0) && wb_hit2 && !iss_hit2);
  assign rf.raw_stall = (rf.rs1_used && rf.rs1_busy) || (rf.rs2_used && rf.rs2_busy);

endmodule

// File: tb/tb_ysyx_24090003_regfile_sb.sv
// Drives a forwarding and a non-forwarding register file in lockstep against a reference model.
module tb_ysyx_24090003_regfile_sb;
  import ysyx_24090003_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic            cpu_clk = 1'b0;
  logic            cpu_rst_n = 1'b0;
  logic [AW-1:0]   rs1, rs2, iss_rd, wb_rd;
  logic            rs1_used, rs2_used, iss_valid, wb_valid;
  logic [XLEN-1:0] wb_data;

  ysyx_24090003_regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_b ();
  ysyx_24090003_regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_n ();

  assign bus_b.rs1 = rs1;             assign bus_n.rs1 = rs1;
  assign bus_b.rs2 = rs2;             assign bus_n.rs2 = rs2;
  assign bus_b.rs1_used = rs1_used;   assign bus_n.rs1_used = rs1_used;
  assign bus_b.rs2_used = rs2_used;   assign bus_n.rs2_used = rs2_used;
  assign bus_b.iss_valid = iss_valid; assign bus_n.iss_valid = iss_valid;
  assign bus_b.iss_rd = iss_rd;       assign bus_n.iss_rd = iss_rd;
  assign bus_b.wb_valid = wb_valid;   assign bus_n.wb_valid = wb_valid;
  assign bus_b.wb_rd = wb_rd;         assign bus_n.wb_rd = wb_rd;
  assign bus_b.wb_data = wb_data;     assign bus_n.wb_data = wb_data;

  ysyx_24090003_regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut_b (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .rf(bus_b));
  ysyx_24090003_regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) dut_n (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .rf(bus_n));

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];

  typedef struct {
    bit          rst_n;
    logic [4:0]  rs1, rs2;
    bit          used1, used2;
    bit          iss_v;
    logic [4:0]  iss_rd;
    bit          wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    bit          chk;
    logic [31:0] e_rd1_b, e_rd1_n;
    bit          e_st_b, e_st_n;
  } vec_t;

  vec_t vecs [17];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rdata(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wb_valid && wb_rd == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_busy_out(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wb_valid && wb_rd == a && !(iss_valid && iss_rd == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_model();
    bit b1, b2, n1, n2;
    b1 = m_busy_out(rs1, 1'b1); b2 = m_busy_out(rs2, 1'b1);
    n1 = m_busy_out(rs1, 1'b0); n2 = m_busy_out(rs2, 1'b0);
    cmp("byp rdata1", bus_b.rdata1, m_rdata(rs1, 1'b1));
    cmp("byp rdata2", bus_b.rdata2, m_rdata(rs2, 1'b1));
    cmp("byp rs1_busy", 32'(bus_b.rs1_busy), 32'(b1));
    cmp("byp rs2_busy", 32'(bus_b.rs2_busy), 32'(b2));
    cmp("byp raw_stall", 32'(bus_b.raw_stall), 32'((rs1_used & b1) | (rs2_used & b2)));
    cmp("nobyp rdata1", bus_n.rdata1, m_rdata(rs1, 1'b0));
    cmp("nobyp rdata2", bus_n.rdata2, m_rdata(rs2, 1'b0));
    cmp("nobyp rs1_busy", 32'(bus_n.rs1_busy), 32'(n1));
    cmp("nobyp rs2_busy", 32'(bus_n.rs2_busy), 32'(n2));
    cmp("nobyp raw_stall", 32'(bus_n.raw_stall), 32'((rs1_used & n1) | (rs2_used & n2)));
  endtask

  task automatic model_edge();
    if (!cpu_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wb_valid && wb_rd != 0) begin
        m_reg[wb_rd] = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic tick(input bit model_chk);
    #2;
    if (model_chk && cpu_rst_n) check_model();
    @(posedge cpu_clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input vec_t v);
    cpu_rst_n = v.rst_n;
    rs1 = v.rs1;           rs2 = v.rs2;
    rs1_used = v.used1;    rs2_used = v.used2;
    iss_valid = v.iss_v;   iss_rd = v.iss_rd;
    wb_valid = v.wb_v;     wb_rd = v.wb_rd;   wb_data = v.wb_data;
  endtask

  initial begin
    vecs[0]  = '{1, 5, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h0, 0, 0};
    vecs[1]  = '{1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{1, 5, 7, 0, 1, 1, 7, 0, 0, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[3]  = '{1, 5, 7, 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1};
    vecs[4]  = '{1, 5, 7, 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1};
    vecs[5]  = '{1, 7, 7, 0, 1, 0, 0, 1, 7, 32'h77, 1, 32'h77, 32'h0, 0, 1};
    vecs[6]  = '{1, 7, 7, 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h77, 32'h77, 0, 0};
    vecs[7]  = '{1, 3, 3, 0, 1, 1, 3, 1, 3, 32'h33, 1, 32'h33, 32'h0, 0, 0};
    vecs[8]  = '{1, 3, 3, 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h33, 32'h33, 1, 1};
    vecs[9]  = '{1, 3, 3, 0, 1, 0, 0, 1, 3, 32'h3333, 1, 32'h3333, 32'h33, 0, 1};
    vecs[10] = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 32'h12345678, 1, 32'h0, 32'h0, 0, 0};
    vecs[11] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0};
    vecs[12] = '{1, 9, 9, 1, 1, 1, 9, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0};
    vecs[13] = '{1, 9, 9, 1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 1, 1};
    vecs[14] = '{0, 9, 9, 1, 1, 0, 0, 1, 9, 32'hABCD, 0, 32'h0, 32'h0, 0, 0};
    vecs[15] = '{1, 9, 9, 1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0};
    vecs[16] = '{1, 5, 7, 1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0};

    // reset with writeback and issue traffic that must be discarded
    drive('{0, 4, 4, 1, 1, 1, 4, 1, 4, 32'hFFFF0000, 0, 32'h0, 32'h0, 0, 0});
    tick(1'b0);
    tick(1'b0);

    for (int i = 0; i < NREG; i++) begin
      drive('{1, 5'(i), 5'(NREG - 1 - i), 1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0});
      #2;
      cmp("sweep byp rdata1", bus_b.rdata1, 32'h0);
      cmp("sweep byp rdata2", bus_b.rdata2, 32'h0);
      cmp("sweep byp busy", 32'({bus_b.rs1_busy, bus_b.rs2_busy, bus_b.raw_stall}), 32'h0);
      cmp("sweep nobyp rdata1", bus_n.rdata1, 32'h0);
      cmp("sweep nobyp busy", 32'({bus_n.rs1_busy, bus_n.rs2_busy, bus_n.raw_stall}), 32'h0);
      tick(1'b0);
    end

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      #2;
      if (vecs[i].chk) begin
        cmp($sformatf("vec%0d byp rdata1", i), bus_b.rdata1, vecs[i].e_rd1_b);
        cmp($sformatf("vec%0d nobyp rdata1", i), bus_n.rdata1, vecs[i].e_rd1_n);
        cmp($sformatf("vec%0d byp raw_stall", i), 32'(bus_b.raw_stall), 32'(vecs[i].e_st_b));
        cmp($sformatf("vec%0d nobyp raw_stall", i), 32'(bus_n.raw_stall), 32'(vecs[i].e_st_n));
      end
      tick(1'b1);
    end

    // x9 and its busy bit after the mid-writeback reset
    drive('{1, 9, 9, 0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0});
    #2;
    cmp("post-reset x9 busy", 32'(bus_b.rs2_busy), 32'h0);
    cmp("post-reset x9 data", bus_n.rdata2, 32'h0);
    tick(1'b1);

    for (int n = 0; n < 800; n++) begin
      cpu_rst_n = ($urandom_range(0, 79) != 0);
      rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd = 5'($urandom_range(0, 7));
      wb_valid = ($urandom_range(0, 1) == 0);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      tick(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
